// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one memory request at a time,
// holds each returned word for decode and applies PC-relative redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_offset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] target;
  logic        misal;
  logic [2:0]  go_st;

  assign target = pc_out_q + redirect_offset;
  assign misal  = |target[1:0];
  assign go_st  = enable ? S_REQ : S_IDLE;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    pend_d     = pend_q;
    if (state_q != S_ERR && redirect_valid && misal) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) fetch_pc_d = target;
          if (enable) state_d = S_REQ;
        end
        S_REQ: begin
          if (mem_ready) begin
            if (redirect_valid) begin
              pend_d  = target;
              state_d = S_FLUSH;
            end else begin
              state_d = S_WAIT;
            end
          end else if (redirect_valid) begin
            fetch_pc_d = target;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (redirect_valid) begin
              fetch_pc_d = target;
              state_d    = go_st;
            end else begin
              instr_d  = mem_rdata;
              pc_out_d = fetch_pc_q;
              state_d  = S_HOLD;
            end
          end else if (redirect_valid) begin
            pend_d  = target;
            state_d = S_FLUSH;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            fetch_pc_d = target;
            state_d    = go_st;
          end else if (ins_ready) begin
            fetch_pc_d = pc_out_q + 32'd4;
            state_d    = go_st;
          end
        end
        S_FLUSH: begin
          // The newest redirect wins over an older pending target
          if (redirect_valid) pend_d = target;
          if (mem_rvalid) begin
            fetch_pc_d = redirect_valid ? target : pend_q;
            state_d    = go_st;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_out_q   <= RESET_PC;
      instr_q    <= NOP_WORD;
      pend_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      pend_q     <= pend_d;
    end
  end

  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = fetch_pc_q;
  assign ins_valid   = (state_q == S_HOLD);
  assign instruction = ins_valid ? instr_q : NOP_WORD;
  assign pc_out      = pc_out_q;
  assign fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, stall, redirects, fault and
// PC wrap, using a second instance with a non-zero reset PC.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        rst2 = 1'b1;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_offset = '0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ins_ready = 1'b0;

  logic        mem_req, ins_valid, fetch_err;
  logic [31:0] mem_addr, instruction, pc_out;
  logic        mem_req2, ins_valid2, fetch_err2;
  logic [31:0] mem_addr2, instruction2, pc_out2;

  int total = 0;
  int passed = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_ctrl dut (
    .CLK(CLK), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_offset(redirect_offset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .instruction(instruction), .pc_out(pc_out), .fetch_err(fetch_err)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .reset(rst2), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_offset(redirect_offset),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid2), .ins_ready(ins_ready),
    .instruction(instruction2), .pc_out(pc_out2), .fetch_err(fetch_err2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  // Enter in REQ at addr, leave in HOLD presenting addr
  task automatic to_hold(input logic [31:0] addr);
    chk32("req_addr", mem_addr, addr);
    chk1("req_on", mem_req, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk1("wait_req_off", mem_req, 1'b0);
    chk1("wait_no_valid", ins_valid, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA000_0000 | addr;
    tick();
    mem_rvalid = 1'b0;
    chk1("hold_valid", ins_valid, 1'b1);
    chk32("hold_pc", pc_out, addr);
    chk32("hold_ins", instruction, 32'hA000_0000 | addr);
  endtask

  task automatic fetch_one(input logic [31:0] addr);
    to_hold(addr);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_valid", ins_valid, 1'b0);
    chk32("rst_ins", instruction, NOP);
    chk32("rst_pc", pc_out, 32'h0);
    chk32("rst_addr", mem_addr, 32'h0);
    chk1("rst_err", fetch_err, 1'b0);

    reset  = 1'b0;
    enable = 1'b1;
    tick();
    fetch_one(32'd0);
    fetch_one(32'd4);

    to_hold(32'd8);
    for (int i = 0; i < 5; i++) begin
      chk1("stall_valid", ins_valid, 1'b1);
      chk32("stall_pc", pc_out, 32'd8);
      chk32("stall_ins", instruction, 32'hA000_0008);
      chk1("stall_req", mem_req, 1'b0);
      tick();
    end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    fetch_one(32'd12);
    fetch_one(32'd16);

    chk32("req20", mem_addr, 32'd20);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk32("wait_pc16", pc_out, 32'd16);
    redirect_valid  = 1'b1;
    redirect_offset = -32'sd8;
    tick();
    redirect_valid = 1'b0;
    chk1("flush_req", mem_req, 1'b0);
    chk32("flush_addr", mem_addr, 32'd20);
    tick();
    chk1("flush_valid", ins_valid, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk1("post_flush_valid", ins_valid, 1'b0);
    chk1("post_flush_req", mem_req, 1'b1);
    chk32("post_flush_addr", mem_addr, 32'd8);

    redirect_valid  = 1'b1;
    redirect_offset = 32'h0000_00F0;
    tick();
    redirect_valid = 1'b0;
    to_hold(32'h100);
    ins_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_offset = 32'h40;
    tick();
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    chk32("hold_redir_addr", mem_addr, 32'h140);
    chk1("hold_redir_req", mem_req, 1'b1);
    chk1("hold_redir_valid", ins_valid, 1'b0);

    reset = 1'b1;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk32("arst_addr", mem_addr, 32'h0);
    chk32("arst_pc", pc_out, 32'h0);
    tick();
    reset           = 1'b0;
    enable          = 1'b0;
    redirect_valid  = 1'b1;
    redirect_offset = 32'd6;
    tick();
    redirect_valid = 1'b0;
    chk1("err_set", fetch_err, 1'b1);
    chk1("err_req", mem_req, 1'b0);
    enable          = 1'b1;
    mem_ready       = 1'b1;
    mem_rvalid      = 1'b1;
    ins_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_offset = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("err_sticky", fetch_err, 1'b1);
      chk1("err_noreq", mem_req, 1'b0);
      chk1("err_novalid", ins_valid, 1'b0);
    end
    mem_ready      = 1'b0;
    mem_rvalid     = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk1("err_clear", fetch_err, 1'b0);
    tick();

    enable = 1'b1;
    rst2   = 1'b0;
    tick();
    chk1("w_req", mem_req2, 1'b1);
    chk32("w_addr0", mem_addr2, 32'hFFFF_FFFC);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk1("w_valid", ins_valid2, 1'b1);
    chk32("w_pc", pc_out2, 32'hFFFF_FFFC);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk32("w_wrap_addr", mem_addr2, 32'h0);
    chk1("w_no_err", fetch_err2, 1'b0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst2 = 1'b1;
    #1;
    chk1("w_rst_req", mem_req2, 1'b0);
    chk32("w_rst_addr", mem_addr2, 32'hFFFF_FFFC);
    chk32("w_rst_ins", instruction2, NOP);
    tick();
    rst2       = 1'b0;
    enable     = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk1("w_stale_valid", ins_valid2, 1'b0);
    chk1("w_stale_req", mem_req2, 1'b0);
    chk32("w_stale_ins", instruction2, NOP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer between a word-aligned, byte-addressed instruction memory and the decode stage. It owns the fetch PC and issues one request at a time over a req/ready + rvalid memory handshake. It presents each returned word downstream with a valid/ready handshake and applies PC-relative redirects from the branch unit. Misaligned redirect targets raise a sticky fetch fault.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be 4-byte aligned.
NOP_WORD, 32'h0000_0013, value driven on instruction while no valid word is held.

Ports:
CLK  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = issue new fetches; 0 = in-flight fetch completes, no new request issued.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_offset  input  32  signed byte offset; target = pc_out + offset.
mem_req  output  1  request to instruction memory.
mem_addr  output  32  fetch byte address; held stable while mem_req=1 and mem_ready=0.
mem_ready  input  1  memory accepts request this cycle when mem_req=1.
mem_rvalid  input  1  read data valid.
mem_rdata  input  32  instruction word, already assembled big-endian by memory.
ins_valid  output  1  instruction/pc_out valid for decode.
ins_ready  input  1  decode consumes the word this cycle when ins_valid=1.
instruction  output  32  held instruction word.
pc_out  output  32  byte address of the presented instruction.
fetch_err  output  1  sticky misaligned-target fault.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; fetch_pc=RESET_PC; pc_out=RESET_PC; mem_addr=RESET_PC; mem_req=0; ins_valid=0; instruction=NOP_WORD; fetch_err=0; no pending target.
- States: IDLE, REQ, WAIT, HOLD, FLUSH, ERR.
- IDLE: to REQ when enable=1. mem_rvalid is ignored here, so a stale response after reset is dropped.
- REQ: mem_req=1, mem_addr=fetch_pc. mem_ready=1 moves to WAIT. Minimum response latency is 1 cycle; mem_rvalid is sampled only in WAIT and FLUSH.
- WAIT: mem_rvalid=1 sets instruction=mem_rdata, pc_out=fetch_pc, ins_valid=1, and moves to HOLD.
- HOLD: ins_valid=1; instruction and pc_out are stable. ins_ready=1 sets fetch_pc=pc_out+4 and ins_valid=0 next cycle, then goes to REQ if enable=1, else IDLE.
- Throughput: one instruction per 3 cycles at best (REQ, WAIT, HOLD).
- Redirect, accepted in every state except ERR; target = pc_out + redirect_offset, computed mod 2^32 with the pc_out value current that cycle:
  - IDLE, or REQ with mem_ready=0: fetch_pc=target next cycle. The request is retargeted; no acceptance has occurred.
  - REQ with mem_ready=1: the request is accepted and its data is unwanted. Go to FLUSH with pending=target.
  - WAIT with mem_rvalid=0: go to FLUSH with pending=target.
  - WAIT with mem_rvalid=1: discard data, fetch_pc=target, go to REQ (or IDLE if enable=0); ins_valid stays 0.
  - HOLD: ins_valid=0 next cycle. If ins_ready=1 the same cycle, the handshake still counts as consumed. fetch_pc=target, go to REQ/IDLE.
  - FLUSH: pending=latest target (last redirect wins).
- FLUSH: mem_req=0, ins_valid=0. mem_rvalid=1 discards the data, sets fetch_pc=pending, then goes to REQ/IDLE.
- Misalignment: a target with bits[1:0]≠0 goes to ERR instead, regardless of the current state. ERR: fetch_err=1, mem_req=0, ins_valid=0, all inputs ignored; exit only by reset.
- Wrap: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, no fault.
- mem_addr equals fetch_pc in every state; only REQ asserts mem_req.

Test Plan:
- Reset release, enable=1, memory ready same cycle, rvalid 1 cycle later, ins_ready=1 -> ins_valid pulses with pc_out 0,4,8,12 every 3 cycles, mem_addr matches each.
- ins_ready=0 for 5 cycles in HOLD with pc_out=8 -> instruction/pc_out stable, mem_req=0 throughout; after ready, next request addr=12.
- Redirect offset=-8 during WAIT with pc_out=16, rvalid 3 cycles later -> returned word discarded, next mem_addr=8, no ins_valid for the discarded word.
- Redirect in HOLD with ins_ready=1 same cycle, pc_out=0x100, offset=0x40 -> next request addr=0x140.
- Redirect offset=6 with pc_out=0 -> fetch_err=1 next cycle, mem_req and ins_valid stay 0 indefinitely; reset clears fetch_err.
- RESET_PC=32'hFFFF_FFFC, consume one word -> next mem_addr=0; assert reset in WAIT -> outputs reset immediately, later rvalid ignored.
